// File: rtl/adc_deser_pkg.sv
// adc_deser_pkg: FSM state type and default parameters shared by adc_serial_deser and its FIFO
package adc_deser_pkg;
   typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;
   localparam int WORD_W_DEF      = 8;
   localparam int FIFO_DEPTH_DEF  = 8;
   localparam int SLP_MARGIN_DEF  = 2;
   localparam int SYNC_STAGES_MIN = 2;
endpackage

// File: rtl/adc_deser_fifo.sv
// adc_deser_fifo: show-ahead synchronous FIFO; pointers carry an extra wrap bit so level is unambiguous
module adc_deser_fifo #(
   parameter int WORD_W     = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_wr,
   input  logic [WORD_W-1:0]             i_wdata,
   input  logic                          i_rd,
   output logic [WORD_W-1:0]             o_rdata,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] P_ONE = 1;
   logic [AW:0]       r_wp, r_rp;
   logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
   logic              w_rd, w_we;
   assign o_level = r_wp - r_rp;
   assign o_empty = r_wp == r_rp;
   assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_rd    = i_rd & ~o_empty;
   assign w_we    = i_wr & (~o_full | w_rd);
   // head is forced to zero when empty so the output is defined straight out of reset
   assign o_rdata = o_empty ? '0 : r_mem[r_rp[AW-1:0]];
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_we) r_wp <= r_wp + P_ONE;
         if (w_rd) r_rp <= r_rp + P_ONE;
      end
   end
   always_ff @(posedge i_clk) begin
      if (w_we) r_mem[r_wp[AW-1:0]] <= i_wdata;
   end
endmodule

// File: rtl/adc_serial_deser.sv
// adc_serial_deser: serial ADC word assembler with FIFO and sleep throttling; ADC_DESER_WORDCNT_EN adds o_word_cnt
module adc_serial_deser
   import adc_deser_pkg::*;
#(
   parameter int WORD_W      = WORD_W_DEF,
   parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
   parameter int SLP_MARGIN  = SLP_MARGIN_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_MIN
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_en,
   input  logic                          i_adc_sclk,
   input  logic                          i_adc_dout,
   output logic                          o_adc_slp,
   output logic [WORD_W-1:0]             o_m_data,
   output logic                          o_m_valid,
   input  logic                          i_m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                          o_overflow
`ifdef ADC_DESER_WORDCNT_EN
   ,
   output logic [15:0]                   o_word_cnt
`endif
);
   localparam int CW = $clog2(WORD_W);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
   localparam logic [CW-1:0] CNT_ONE  = 1;
   localparam logic [LW-1:0] SLP_LVL  = LW'(FIFO_DEPTH - SLP_MARGIN);
   state_t                 r_state, w_next;
   logic [SYNC_STAGES-1:0] r_sclk_sync, r_dout_sync;
   logic                   r_sclk_prev, r_slp, r_overflow;
   logic [CW-1:0]          r_cnt;
   logic [WORD_W-2:0]      r_sr;
   logic                   w_sclk, w_dout, w_fall, w_cap, w_last, w_wr, w_hi;
   logic                   w_full, w_empty, w_rd, w_slp;
   assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
   assign w_dout       = r_dout_sync[SYNC_STAGES-1];
   assign w_fall       = r_sclk_prev & ~w_sclk;
   // STALL still captures so edges already in flight when sleep asserts are not lost
   assign w_cap        = w_fall && (r_state != IDLE);
   assign w_last       = r_cnt == LAST_BIT;
   assign w_wr         = w_cap & w_last;
   assign w_hi         = o_fifo_level >= SLP_LVL;
   assign w_rd         = ~w_empty & i_m_ready;
   assign o_m_valid    = ~w_empty;
   assign o_adc_slp    = r_slp;
   assign o_overflow   = r_overflow;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = i_en ? RUN : IDLE;
         RUN:     w_next = !i_en ? IDLE : (w_hi ? STALL : RUN);
         STALL:   w_next = !i_en ? IDLE : (w_hi ? STALL : RUN);
         default: w_next = IDLE;
      endcase
      w_slp = w_next != RUN;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sclk_sync <= '0;
         r_dout_sync <= '0;
         r_sclk_prev <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_adc_sclk};
         r_dout_sync <= {r_dout_sync[SYNC_STAGES-2:0], i_adc_dout};
         r_sclk_prev <= w_sclk;
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_slp      <= 1'b1;
         r_cnt      <= '0;
         r_sr       <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_slp      <= w_slp;
         r_cnt      <= (r_state == IDLE) ? '0 : (w_cap ? (w_last ? '0 : r_cnt + CNT_ONE) : r_cnt);
         if (w_cap) r_sr <= {r_sr[WORD_W-3:0], w_dout};
         if (w_wr && w_full && !w_rd) r_overflow <= 1'b1;
      end
   end
`ifdef ADC_DESER_WORDCNT_EN
   logic [15:0] r_word_cnt;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_word_cnt <= '0;
      else if (w_wr && (!w_full || w_rd)) r_word_cnt <= r_word_cnt + 16'd1;
   end
   assign o_word_cnt = r_word_cnt;
`endif
   adc_deser_fifo #(
      .WORD_W     (WORD_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_wr    (w_wr),
      .i_wdata ({r_sr, w_dout}),
      .i_rd    (i_m_ready),
      .o_rdata (o_m_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (o_fifo_level)
   );
endmodule

// File: tb/tb_adc_serial_deser.sv
// tb_adc_serial_deser: bench ADC drives MSB-first words; a scoreboard queue holds the words expected on m_data
module tb_adc_serial_deser;
   logic       clk = 0, rst_n = 0, en = 0, sclk = 0, dout = 0;
   logic       slp, m_valid, overflow, rnd_rdy = 0;
   logic [7:0] m_data, mon_exp;
   logic [3:0] level;
   wire        m_ready;
   int         vectors = 0, miscompares = 0, rdy_mode = 0, exp_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] t2w[9];
`ifdef ADC_DESER_WORDCNT_EN
   logic [15:0] word_cnt;
`endif
   assign m_ready = (rdy_mode == 2) ? rnd_rdy : (rdy_mode == 1);
   always #5 clk = ~clk;
   adc_serial_deser dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_adc_sclk(sclk), .i_adc_dout(dout),
      .o_adc_slp(slp), .o_m_data(m_data), .o_m_valid(m_valid), .i_m_ready(m_ready),
      .o_fifo_level(level), .o_overflow(overflow)
`ifdef ADC_DESER_WORDCNT_EN
      , .o_word_cnt(word_cnt)
`endif
   );
   initial forever begin
      @(posedge clk);
      #1 rnd_rdy = 1'($urandom_range(0, 1));
   end
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_word: got %02h, no word expected", m_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (m_data !== mon_exp) begin
               miscompares++;
               $display("FAIL m_data: got %02h, expected %02h", m_data, mon_exp);
            end
         end
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_slp"}, 32'(slp), 1);
      chk({tag, "_valid"}, 32'(m_valid), 0);
      chk({tag, "_data"}, 32'(m_data), 0);
      chk({tag, "_level"}, 32'(level), 0);
      chk({tag, "_overflow"}, 32'(overflow), 0);
`ifdef ADC_DESER_WORDCNT_EN
      chk({tag, "_word_cnt"}, 32'(word_cnt), 0);
`endif
   endtask
   task automatic chk_cnt(input string nm);
`ifdef ADC_DESER_WORDCNT_EN
      chk(nm, 32'(word_cnt), 32'(exp_cnt[15:0]));
`endif
   endtask
   task automatic push_word(input logic [7:0] w);
      exp_q.push_back(w);
      exp_cnt++;
   endtask
   // bench ADC: one bit per 8 clk periods, data changes just after the rising edge, gated by slp when obeyed
   task automatic send_bits(input logic [7:0] w, input int n, input bit obey, input bit push);
      for (int i = 0; i < n; i++) begin
         if (obey) begin
            int t = 0;
            while (slp && t < 3000) begin
               cyc(1);
               t++;
            end
            if (t >= 3000) chk("slp_wait_timeout", 32'(slp), 0);
         end
         sclk = 1;
         cyc(1);
         dout = w[7-i];
         cyc(3);
         sclk = 0;
         if (push && i == 7) push_word(w);
         cyc(4);
      end
   endtask
   task automatic wait_drain(input string nm);
      int t = 0;
      cyc(8);
      while ((exp_q.size() != 0 || m_valid) && t < 3000) begin
         cyc(1);
         t++;
      end
      if (t >= 3000) chk({nm, "_drain_timeout"}, 32'(exp_q.size()), 0);
   endtask
   task automatic do_reset();
      rst_n = 0;
      en = 0;
      sclk = 0;
      dout = 0;
      rdy_mode = 0;
      exp_q.delete();
      exp_cnt = 0;
      cyc(3);
      rst_n = 1;
      cyc(2);
   endtask
   initial begin
      logic [7:0] w;
      do_reset();
      chk_reset("reset");
      // release from sleep and alternating pattern
      rdy_mode = 1;
      en = 1;
      #2 chk("slp_before_edge", 32'(slp), 1);
      cyc(1);
      chk("slp_after_en", 32'(slp), 0);
      for (int i = 0; i < 4; i++) send_bits((i % 2) ? 8'hAA : 8'h55, 8, 1, 1);
      wait_drain("pattern");
      // random words with random consumer stalls
      rdy_mode = 2;
      for (int i = 0; i < 12; i++) send_bits(8'($urandom_range(0, 255)), 8, 1, 1);
      rdy_mode = 1;
      wait_drain("random");
      // backpressure throttles the ADC through sleep
      for (int i = 0; i < 9; i++) t2w[i] = 8'($urandom_range(0, 255));
      rdy_mode = 0;
      fork
         begin
            for (int i = 0; i < 9; i++) send_bits(t2w[i], 8, 1, 1);
         end
         begin
            int t = 0;
            while (level < 6 && t < 3000) begin
               cyc(1);
               t++;
            end
            chk("bp_reach_6", 32'(t < 3000), 1);
            cyc(200);
            chk("bp_slp", 32'(slp), 1);
            chk("bp_level_6_or_7", 32'(level == 6 || level == 7), 1);
            chk("bp_overflow", 32'(overflow), 0);
            rdy_mode = 1;
         end
      join
      wait_drain("backpressure");
      // abort mid-word keeps FIFO contents and discards partial bits
      rdy_mode = 0;
      send_bits(8'($urandom_range(0, 255)), 8, 1, 1);
      send_bits(8'($urandom_range(0, 255)), 5, 1, 0);
      en = 0;
      cyc(2);
      chk("abort_slp", 32'(slp), 1);
      chk("abort_level", 32'(level), 1);
      en = 1;
      cyc(2);
      send_bits(8'($urandom_range(0, 255)), 8, 1, 1);
      cyc(8);
      chk("abort_level_after", 32'(level), 2);
      rdy_mode = 1;
      wait_drain("abort");
      // full FIFO, read coinciding with the completing write
      rdy_mode = 0;
      for (int i = 0; i < 8; i++) send_bits(8'($urandom_range(0, 255)), 8, 0, 1);
      cyc(8);
      chk("full_level", 32'(level), 8);
      w = 8'($urandom_range(0, 255));
      send_bits(w, 7, 0, 0);
      sclk = 1;
      cyc(1);
      dout = w[0];
      cyc(3);
      sclk = 0;
      push_word(w);
      cyc(2);
      rdy_mode = 1;
      cyc(1);
      rdy_mode = 0;
      chk("rdwr_level", 32'(level), 8);
      chk("rdwr_overflow", 32'(overflow), 0);
      chk_cnt("rdwr_word_cnt");
      rdy_mode = 1;
      wait_drain("rdwr");
      chk("rdwr_overflow_after", 32'(overflow), 0);
      // ninth word into a full FIFO is dropped
      rdy_mode = 0;
      for (int i = 0; i < 9; i++) send_bits(8'($urandom_range(0, 255)), 8, 0, i < 8);
      cyc(8);
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_level", 32'(level), 8);
      chk_cnt("ovf_word_cnt");
      rdy_mode = 1;
      wait_drain("ovf");
      chk("ovf_sticky", 32'(overflow), 1);
      // asynchronous reset mid-word with three words queued
      rdy_mode = 0;
      for (int i = 0; i < 3; i++) send_bits(8'($urandom_range(0, 255)), 8, 1, 1);
      send_bits(8'($urandom_range(0, 255)), 4, 1, 0);
      cyc(1);
      chk("pre_reset_level", 32'(level), 3);
      #3 rst_n = 0;
      #1 chk_reset("async_reset");
      exp_q.delete();
      exp_cnt = 0;
      en = 0;
      sclk = 0;
      dout = 0;
      cyc(2);
      rst_n = 1;
      en = 1;
      rdy_mode = 1;
      send_bits(8'($urandom_range(0, 255)), 8, 1, 1);
      wait_drain("post_reset");
      chk_cnt("final_word_cnt");
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
